// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter and its
// round-robin picker.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of an index into n items; never below one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// the pointer, wrapping modulo N. Returns one-hot and index of the winner.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int k = 0; k < N; k++) begin
            w_j = PW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_any         = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between N_REQ
// masters, with per-owner bus lock and forced release after LOCK_MAX cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wd,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rd,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wd,
    input  logic [DW-1:0]       mem_rd,
    output logic                lock_err
);

    localparam int PW = ptr_w(N_REQ);
    localparam int CW = ptr_w(LOCK_MAX);

    arb_state_e       r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_owner, w_owner_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_rvalid;
    logic             r_lock_err;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_win;
    logic             w_acc;
    logic             w_release;
    logic             w_timeout;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] x);
        return PW'((int'(x) + 1) % N_REQ);
    endfunction

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_rvalid   <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rvalid   <= w_gnt & ~we;
            r_lock_err <= w_timeout;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_acc) begin
                    w_ptr_nxt = f_next(w_win);
                    if (lock[w_win]) begin
                        w_state_nxt = ARB_LOCKED;
                        w_owner_nxt = w_win;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                // Dropping lock releases whether or not the owner also accesses.
                w_release = !lock[r_owner];
                w_timeout = !w_release && (r_cnt == CW'(LOCK_MAX - 1));
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_release || w_timeout) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = f_next(r_owner);
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_gnt    = '0;
        w_win    = w_pick_idx;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (r_state == ARB_IDLE) begin
            if (w_pick_any) begin
                w_gnt = w_pick_onehot;
            end
        end else begin
            w_win = r_owner;
            if (req[r_owner]) begin
                w_gnt[r_owner] = 1'b1;
            end
        end
        w_acc = |w_gnt;
        if (w_acc) begin
            mem_we   = we[w_win];
            mem_addr = addr[int'(w_win)*AW +: AW];
            mem_wd   = wd[int'(w_win)*DW +: DW];
        end
    end

    assign gnt      = w_gnt;
    assign rvalid   = r_rvalid;
    assign rd       = mem_rd;
    assign lock_err = r_lock_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: synchronous memory model, directed
// requester stimulus and a read-return scoreboard.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LM = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wd;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rd;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wd;
    logic [DW-1:0]   mem_rd;
    logic            lock_err;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] tb_mem [0:63];

    dmem_arbiter #(
        .N_REQ    (N),
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (LM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wd       (wd),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rd       (rd),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .lock_err (lock_err)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, read-before-write.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wd;
        mem_rd <= tb_mem[mem_addr[7:2]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic l,
                           input logic [31:0] a, input logic [31:0] d);
        req[i]            = r;
        we[i]             = w;
        lock[i]           = l;
        addr[i*AW +: AW]  = a;
        wd[i*DW +: DW]    = d;
    endtask

    task automatic clear_all();
        req  = '0;
        we   = '0;
        lock = '0;
        addr = '0;
        wd   = '0;
    endtask

    task automatic push_exp(input int i, input logic [31:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every read return is matched against the oldest predicted one.
    always @(negedge clk) begin
        if (rvalid !== '0) begin
            if (sb.size() == 0) begin
                check_val("rv_unexpected", 32'(rvalid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("rv_idx", 32'(rvalid), 32'(1 << mon_e.idx));
                check_val("rd_data", rd, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        check_val("watchdog", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 64; k++) tb_mem[k] <= 32'h1000_0000 + k;
        clear_all();
        rst = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_rvalid", 32'(rvalid), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_lock_err", 32'(lock_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_gnt", 32'(gnt), 32'd0);
        check_val("idle_mem_we", 32'(mem_we), 32'd0);
        check_val("idle_mem_addr", mem_addr, 32'd0);
        check_val("idle_mem_wd", mem_wd, 32'd0);
        next_cycle();

        // Round robin: all four load together, grants 0..3 in order.
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 1'b0, 1'b0, 32'h10 + 32'(4 * i), 32'd0);
            push_exp(i, 32'h1000_0004 + 32'(i));
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check_val("rr_gnt", 32'(gnt), 32'(1 << k));
            check_val("rr_addr", mem_addr, 32'h10 + 32'(4 * k));
            check_val("rr_mem_we", 32'(mem_we), 32'd0);
            next_cycle();
        end
        clear_all();

        // Write then read back through another requester.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("wr_gnt", 32'(gnt), 32'b0001);
        check_val("wr_mem_we", 32'(mem_we), 32'd1);
        check_val("wr_addr", mem_addr, 32'h40);
        check_val("wr_wd", mem_wd, 32'hDEAD_BEEF);
        next_cycle();
        clear_all();
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        push_exp(2, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("rd_gnt", 32'(gnt), 32'b0100);
        check_val("rd_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        clear_all();
        @(negedge clk);
        check_val("wr_idle_gnt", 32'(gnt), 32'd0);
        check_val("wr_idle_we", 32'(mem_we), 32'd0);
        next_cycle();

        // ptr is 3; a store by req0 moves it to 1.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h55);
        @(negedge clk);
        check_val("pre_gnt", 32'(gnt), 32'b0001);
        next_cycle();
        clear_all();

        // Lock: req1 owns the bus while req0 and req3 wait.
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'd0);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h24, 32'd0);
        set_req(3, 1'b1, 1'b0, 1'b0, 32'h28, 32'd0);
        push_exp(1, 32'h1000_0008);
        @(negedge clk);
        check_val("lk_first", 32'(gnt), 32'b0010);
        next_cycle();
        push_exp(1, 32'h1000_0008);
        @(negedge clk);
        check_val("lk_hold", 32'(gnt), 32'b0010);
        next_cycle();
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFE_0001);
        @(negedge clk);
        check_val("lk_store_gnt", 32'(gnt), 32'b0010);
        check_val("lk_store_we", 32'(mem_we), 32'd1);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push_exp(3, 32'h1000_000A);
        @(negedge clk);
        check_val("lk_skip2", 32'(gnt), 32'b1000);
        next_cycle();
        set_req(3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        push_exp(0, 32'h1000_0009);
        @(negedge clk);
        check_val("lk_then0", 32'(gnt), 32'b0001);
        next_cycle();
        clear_all();

        // Timeout: req2 keeps lock without requesting; req0 waits.
        set_req(2, 1'b1, 1'b0, 1'b1, 32'h2C, 32'd0);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h24, 32'd0);
        push_exp(2, 32'h1000_000B);
        @(negedge clk);
        check_val("to_own_gnt", 32'(gnt), 32'b0100);
        check_val("to_own_err", 32'(lock_err), 32'd0);
        next_cycle();
        set_req(2, 1'b0, 1'b0, 1'b1, 32'h2C, 32'd0);
        for (int c = 0; c < LM; c++) begin
            @(negedge clk);
            check_val("to_wait_gnt", 32'(gnt), 32'd0);
            check_val("to_no_err", 32'(lock_err), 32'd0);
            next_cycle();
        end
        push_exp(0, 32'h1000_0009);
        @(negedge clk);
        check_val("to_err", 32'(lock_err), 32'd1);
        check_val("to_gnt0", 32'(gnt), 32'b0001);
        next_cycle();
        clear_all();
        @(negedge clk);
        check_val("to_err_once", 32'(lock_err), 32'd0);
        next_cycle();

        // Reset while a locked load is in flight.
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'd0);
        @(negedge clk);
        check_val("rst_ld_gnt", 32'(gnt), 32'b0010);
        next_cycle();
        rst = 1'b0;
        clear_all();
        @(negedge clk);
        check_val("rst_rv_drop", 32'(rvalid), 32'd0);
        check_val("rst_mid_gnt", 32'(gnt), 32'd0);
        next_cycle();
        rst = 1'b1;
        set_req(3, 1'b1, 1'b0, 1'b0, 32'h28, 32'd0);
        push_exp(3, 32'h1000_000A);
        @(negedge clk);
        check_val("rst_lock_clr", 32'(gnt), 32'b1000);
        check_val("rst_no_err", 32'(lock_err), 32'd0);
        next_cycle();
        clear_all();
        repeat (3) @(negedge clk);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between `N_REQ` MIPS cores (or a core and a loader/DMA master) with round-robin arbitration and an optional per-requester bus lock for atomic read-modify-write sequences. It sits between the cores' data-memory ports and the memory macro. It issues at most one memory access per cycle and returns read data one cycle later, tagged to the winning requester.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `AW`, 32: address width
- `DW`, 32: data width
- `LOCK_MAX`, 16: maximum cycles a lock may be held before forced release (≥2)

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low (0 = reset)
- `req` in N_REQ: per-requester access request
- `we` in N_REQ: per-requester write enable (1 = store, 0 = load)
- `lock` in N_REQ: requester wants ownership retained after this access
- `addr` in N_REQ*AW: packed addresses, requester i at [i*AW +: AW]
- `wd` in N_REQ*DW: packed write data, requester i at [i*DW +: DW]
- `gnt` out N_REQ: one-hot grant, combinational, same cycle as accepted request
- `rvalid` out N_REQ: one-hot read-data valid, registered
- `rd` out DW: read data broadcast to all requesters, valid where `rvalid[i]`=1
- `mem_we` out 1: memory write enable
- `mem_addr` out AW: memory address
- `mem_wd` out DW: memory write data
- `mem_rd` in DW: memory read data, synchronous read, valid one cycle after address
- `lock_err` out 1: one-cycle pulse on forced lock release

## Operation
- A requester holds `req`/`we`/`lock`/`addr`/`wd` stable until it sees `gnt[i]`=1 in that cycle. The access completes at that edge.
- State machine with two states: `IDLE` (free arbitration) and `LOCKED` (owner only).
- **IDLE**
  - Winner = first `req[i]` scanning i = ptr, ptr+1, … mod N_REQ.
  - `gnt[winner]`=1. `mem_*` = winner's fields. `mem_we` = `we[winner]`.
  - At the edge: ptr ← winner+1 mod N_REQ.
  - If `lock[winner]`=1: owner ← winner, go to `LOCKED`, lock counter ← 0.
  - With no request: `gnt`=0, `mem_we`=0, `mem_addr`/`mem_wd` = 0.
- **LOCKED**
  - Only the owner may be granted. Other requests wait; `gnt` for them is 0.
  - Owner access with `lock`=1 keeps the lock.
  - Owner access with `lock`=0 completes and releases: next state `IDLE`, ptr ← owner+1.
  - Owner dropping both `req` and `lock` also releases, with no access.
  - The lock counter increments every `LOCKED` cycle. In the cycle it equals `LOCK_MAX`-1 without a release:
    - any owner access in that cycle still proceeds;
    - then state goes to `IDLE`, ptr ← owner+1, `lock_err`=1 for one cycle.
  - If release and timeout coincide, the release wins and `lock_err` stays 0.
- **Reads:** a granted access with `we`=0 sets `rvalid[winner]`=1 in the next cycle with `rd` = `mem_rd`. Writes produce no `rvalid`.
- **Reset values:** state `IDLE`, ptr 0, owner 0, lock counter 0, `rvalid` 0, `lock_err` 0. `rd` passes `mem_rd` but is qualified by `rvalid`.
- **Reset mid-operation:** an in-flight read's `rvalid` is dropped and any lock is cleared. Requesters must reissue.

## Timing
- Grant latency is 0 cycles when the memory is free: `gnt` is combinational from `req`, ptr and state.
- Read latency is 1 cycle from grant to `rvalid`/`rd`.
- Throughput is one access per cycle. Back-to-back grants to different requesters are allowed.
- Worst-case wait without locks is N_REQ-1 cycles. With locks it is (N_REQ-1)*LOCK_MAX + N_REQ-1.
- `lock_err` is registered and asserted in the first `IDLE` cycle after a forced release.

## Structure
- Package `dmem_arb_pkg`: state enum (`ARB_IDLE`, `ARB_LOCKED`), `ptr_w` = $clog2(N_REQ) helper.
- Sub-module `rr_pick`: combinational, takes the `req` vector and ptr, returns one-hot and index of the winner. It is reused for other shared resources.
- Top level contains the FSM, ptr/owner/counter registers, the `mem_*` mux and the `rvalid` pipeline register.

## Test plan
- **Reset then all idle:** `rst`=0→1 → `gnt`=0, `rvalid`=0, `mem_we`=0, ptr=0.
- **Round-robin:** `req`=4'b1111, all loads, held 4 cycles → grants 0,1,2,3 in order; each `rvalid[i]` follows one cycle later with `rd`=`mem_rd`.
- **Write then read:** req0 writes 0xDEADBEEF to 0x40; next cycle req2 reads 0x40 → `mem_we`=1 for one cycle only; `rvalid[2]`=1 with 0xDEADBEEF.
- **Lock:** req1 load with `lock`=1 while req0 and req3 request → only req1 granted until its `lock`=0 store. Then req2 (idle) is skipped and req3 is granted next.
- **Timeout:** req2 holds `lock`=1 and `req`=0, `LOCK_MAX`=16 → forced release after 16 cycles, `lock_err` pulses once, waiting req0 granted in the following cycle.
- **Reset during read:** `rst`=0 in the cycle after a granted load → `rvalid` stays 0, state `IDLE`, held lock cleared.
